data_memory_responder: RTL and testbench
========================================

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning edges from request accept to completion, legal range 1..15.
REQ-002 SHALL have parameter ADDR_BITS, default 12, meaning log2 of memory size in bytes.
REQ-003 SHALL have one clock and a synchronous, active-low reset, named clk and rst_b.
REQ-004 SHALL have port clk  input  1  rising-edge clock.
REQ-005 SHALL have port rst_b  input  1  synchronous active-low reset.
REQ-006 SHALL have port req_valid  input  1  access request from the cache controller.
REQ-007 SHALL have port we_memory  input  1  1 = write (dirty-line writeback), 0 = read (line fill).
REQ-008 SHALL have port mem_addr  input  32  byte address of the access.
REQ-009 SHALL have port mem_data_in  input  4 x 8  write data byte lanes [0:3].
REQ-010 SHALL have port mem_data_out  output  4 x 8  read data byte lanes [0:3], registered.
REQ-011 SHALL have port mem_ready  output  1  one-cycle completion pulse, registered.
REQ-012 SHALL have port mem_busy  output  1  high while a request is in flight.

Function
REQ-013 SHALL hold 2^ADDR_BITS bytes of storage, word-organised, with lane i at byte address {word_index, i}.
REQ-014 SHALL derive the word index from mem_addr[ADDR_BITS-1:2]: bits [1:0] are ignored and upper bits alias (wrap-around).
REQ-015 SHALL implement FSM states IDLE and BUSY.
REQ-016 SHALL accept a request at a rising edge only when state is IDLE, rst_b=1 and req_valid=1; address, we_memory and all mem_data_in lanes are latched at that edge.
REQ-017 SHALL, on accept, load the counter with LATENCY-1 and move to BUSY.
REQ-018 SHALL ignore req_valid, mem_addr, we_memory and mem_data_in while in BUSY: no queueing, and the latched values are unaffected.
REQ-019 SHALL, in BUSY, decrement the counter each edge while it is nonzero.
REQ-020 SHALL, at the BUSY edge where the counter is 0, perform the access, set mem_ready=1 and return to IDLE.
- Completion occurs at edge k+LATENCY for accept edge k.
REQ-021 SHALL, on read completion, load mem_data_out with the four stored bytes of the latched word.
REQ-022 SHALL, on write completion, write all four latched lanes to the latched word and leave mem_data_out unchanged.
REQ-023 SHALL drive mem_ready high for exactly one cycle per completed request and low at every other edge.
REQ-024 SHALL hold mem_data_out from one read completion until the next read completion.
REQ-025 SHALL drive mem_busy=1 exactly when state is BUSY.
REQ-026 SHALL accept a new request at the edge following completion (back-to-back), while mem_ready is still high.
- Minimum spacing between accepts is LATENCY+1 edges.
REQ-027 SHALL perform no storage access when LATENCY=1 other than the single completion one edge after accept.

Reset
REQ-028 SHALL, at any edge with rst_b=0, set state IDLE, counter 0, mem_ready 0, mem_busy 0 and all mem_data_out lanes 8'h00.
REQ-029 SHALL abort an in-flight request when reset is applied mid-operation: no storage write and no mem_ready pulse, including when reset coincides with the completion edge.
REQ-030 SHALL NOT clear storage contents on reset; contents are preloadable for simulation.
REQ-031 SHALL NOT accept req_valid at an edge with rst_b=0.

Verification
REQ-032 SHALL cover write then read:
- Stimulus: LATENCY=4; write addr 0x40 with lanes {11,22,33,44}, then read 0x40.
- Response: each mem_ready pulses exactly 4 edges after its accept; mem_data_out = {11,22,33,44}.
REQ-033 SHALL cover requests while busy:
- Stimulus: req_valid held high with changing addr/data during BUSY.
- Response: only the first request is serviced; mem_busy=1 for 4 cycles; one mem_ready pulse.
REQ-034 SHALL cover aliasing and ignored low bits:
- Stimulus: write 0x1004 with ADDR_BITS=12, then read 0x0006.
- Response: data returned equals the written data.
REQ-035 SHALL cover reset mid-write:
- Stimulus: rst_b=0 at the second BUSY edge of a write to 0x80.
- Response: outputs zero, no mem_ready, and a later read of 0x80 returns the prior contents.
REQ-036 SHALL cover back-to-back requests:
- Stimulus: LATENCY=1; read requests at consecutive accept opportunities.
- Response: a mem_ready pulse every 2 cycles with correct data.
REQ-037 SHALL cover a write not disturbing read data:
- Stimulus: a write completes after a read.
- Response: mem_data_out retains the read value.

Source files
------------

// File: rtl/data_memory_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_memory_responder
//  Description : Fixed-latency, word-organised backing memory for a cache
//                controller. Accepts one read (line fill) or write (dirty-line
//                writeback) at a time and completes it LATENCY edges later
//                with a one-cycle mem_ready pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_memory_responder #(
    parameter int LATENCY   = 4,   // edges from accept to completion, 1..15
    parameter int ADDR_BITS = 12   // log2 of storage size in bytes
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        req_valid,
    input  logic        we_memory,
    input  logic [31:0] mem_addr,
    input  logic [7:0]  mem_data_in  [0:3],
    output logic [7:0]  mem_data_out [0:3],
    output logic        mem_ready,
    output logic        mem_busy
);

    localparam int         c_IDX_BITS = ADDR_BITS - 2;
    localparam int         c_WORDS    = 2 ** c_IDX_BITS;
    localparam logic [3:0] c_CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic                  w_accept;
    logic                  w_complete;
    logic [3:0]            r_count;
    logic                  r_we;
    logic [c_IDX_BITS-1:0] r_idx;
    logic [7:0]            r_wdata [0:3];

    // Byte storage, one row per word; never cleared so it can be preloaded.
    logic [7:0]            r_mem [0:c_WORDS-1][0:3];

    // Low byte-offset bits and aliased upper address bits play no role.
    logic                  w_unused_addr_bits;
    assign w_unused_addr_bits = ^{mem_addr[31:ADDR_BITS], mem_addr[1:0]};

    assign mem_busy = (r_state == BUSY);

    // Next-state logic: accept only from IDLE, complete when the countdown hits 0.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                if (r_count == 4'd0) begin
                    w_complete   = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Control state, latency counter and registered outputs; reset aborts any access.
    always_ff @(posedge clk) begin
        if (!rst_b) begin
            r_state   <= IDLE;
            r_count   <= 4'd0;
            mem_ready <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                mem_data_out[i] <= 8'h00;
            end
        end else begin
            r_state   <= w_state_next;
            mem_ready <= w_complete;
            if (w_accept) begin
                r_count <= c_CNT_LOAD;
            end else if ((r_state == BUSY) && (r_count != 4'd0)) begin
                r_count <= r_count - 4'd1;
            end
            if (w_complete && !r_we) begin
                for (int i = 0; i < 4; i++) begin
                    mem_data_out[i] <= r_mem[r_idx][i];
                end
            end
        end
    end

    // Request capture at accept; held untouched for the whole BUSY period.
    always_ff @(posedge clk) begin
        if (rst_b && w_accept) begin
            r_we  <= we_memory;
            r_idx <= mem_addr[ADDR_BITS-1:2];
            for (int i = 0; i < 4; i++) begin
                r_wdata[i] <= mem_data_in[i];
            end
        end
    end

    // Storage write happens only on a non-reset write completion.
    always_ff @(posedge clk) begin
        if (rst_b && w_complete && r_we) begin
            for (int i = 0; i < 4; i++) begin
                r_mem[r_idx][i] <= r_wdata[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_memory_responder
//  Description : Self-checking bench for data_memory_responder; one instance
//                with LATENCY=4 and one with LATENCY=1, compared against a
//                word-level memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory_responder;

    localparam int c_L0 = 4;
    localparam int c_L1 = 1;

    bit          clk = 1'b0;
    logic        rst_b     [2];
    logic        req_valid [2];
    logic        we_memory [2];
    logic [31:0] mem_addr  [2];
    logic        mem_ready [2];
    logic        mem_busy  [2];
    logic [7:0]  din0  [0:3];
    logic [7:0]  din1  [0:3];
    logic [7:0]  dout0 [0:3];
    logic [7:0]  dout1 [0:3];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: word contents keyed by instance*1024 + word index.
    logic [31:0] model [int];
    logic [31:0] last_rd [2];
    int          wq0 [$];
    int          wq1 [$];

    always #5 clk = ~clk;

    data_memory_responder #(.LATENCY(c_L0), .ADDR_BITS(12)) u_dut0 (
        .clk(clk), .rst_b(rst_b[0]), .req_valid(req_valid[0]), .we_memory(we_memory[0]),
        .mem_addr(mem_addr[0]), .mem_data_in(din0), .mem_data_out(dout0),
        .mem_ready(mem_ready[0]), .mem_busy(mem_busy[0])
    );

    data_memory_responder #(.LATENCY(c_L1), .ADDR_BITS(12)) u_dut1 (
        .clk(clk), .rst_b(rst_b[1]), .req_valid(req_valid[1]), .we_memory(we_memory[1]),
        .mem_addr(mem_addr[1]), .mem_data_in(din1), .mem_data_out(dout1),
        .mem_ready(mem_ready[1]), .mem_busy(mem_busy[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_din(input int sel, input logic [31:0] d);
        for (int i = 0; i < 4; i++) begin
            if (sel == 0) din0[i] = d[8*i +: 8];
            else          din1[i] = d[8*i +: 8];
        end
    endtask

    function automatic logic [31:0] get_dout(input int sel);
        if (sel == 0) return {dout0[3], dout0[2], dout0[1], dout0[0]};
        return {dout1[3], dout1[2], dout1[1], dout1[0]};
    endfunction

    function automatic int key_of(input int sel, input logic [31:0] addr);
        return sel * 1024 + int'(addr[11:2]);
    endfunction

    // One full transaction; called at posedge+1. junk keeps req_valid high with
    // random payload throughout BUSY, which must be ignored.
    task automatic do_req(input int sel, input bit we, input logic [31:0] addr,
                          input logic [31:0] data, input bit junk);
        int lat;
        lat = (sel == 0) ? c_L0 : c_L1;
        req_valid[sel] = 1'b1;
        we_memory[sel] = we;
        mem_addr[sel]  = addr;
        set_din(sel, data);
        @(posedge clk); #1;
        chk("accept_busy", 32'(mem_busy[sel]), 32'd1);
        chk("accept_ready", 32'(mem_ready[sel]), 32'd0);
        for (int i = 1; i <= lat; i++) begin
            if (junk) begin
                req_valid[sel] = 1'b1;
                we_memory[sel] = 1'($urandom);
                mem_addr[sel]  = $urandom;
                set_din(sel, $urandom);
            end else begin
                req_valid[sel] = 1'b0;
            end
            @(posedge clk); #1;
            if (i < lat) begin
                chk("inflight_busy", 32'(mem_busy[sel]), 32'd1);
                chk("inflight_ready", 32'(mem_ready[sel]), 32'd0);
            end
        end
        req_valid[sel] = 1'b0;
        if (we) model[key_of(sel, addr)] = data;
        else    last_rd[sel] = model[key_of(sel, addr)];
        chk("done_ready", 32'(mem_ready[sel]), 32'd1);
        chk("done_busy", 32'(mem_busy[sel]), 32'd0);
        chk("done_data", get_dout(sel), last_rd[sel]);
    endtask

    task automatic idle(input int sel, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            chk("idle_ready", 32'(mem_ready[sel]), 32'd0);
            chk("idle_busy", 32'(mem_busy[sel]), 32'd0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int          idx;
        for (int s = 0; s < 2; s++) begin
            rst_b[s] = 1'b0; req_valid[s] = 1'b1; we_memory[s] = 1'b1;
            mem_addr[s] = 32'h0; last_rd[s] = 32'h0;
        end
        set_din(0, 32'hFFFF_FFFF);
        set_din(1, 32'hFFFF_FFFF);
        repeat (3) @(posedge clk);
        #1;
        // Reset state, with req_valid asserted during reset
        for (int s = 0; s < 2; s++) begin
            chk("rst_ready", 32'(mem_ready[s]), 32'd0);
            chk("rst_busy", 32'(mem_busy[s]), 32'd0);
            chk("rst_data", get_dout(s), 32'h0);
            req_valid[s] = 1'b0;
            rst_b[s] = 1'b1;
        end
        idle(0, 2);

        // Write then read at 0x40
        do_req(0, 1'b1, 32'h40, 32'h44332211, 1'b0);
        idle(0, 1);
        do_req(0, 1'b0, 32'h40, 32'h0, 1'b0);
        chk("wr_rd_40", get_dout(0), 32'h44332211);
        idle(0, 1);
        chk("ready_one_cycle", 32'(mem_ready[0]), 32'd0);

        // Requests while busy are ignored
        do_req(0, 1'b1, 32'h200, 32'hCAFE_F00D, 1'b1);
        idle(0, 2);
        do_req(0, 1'b0, 32'h200, 32'h0, 1'b0);
        chk("busy_ignore", get_dout(0), 32'hCAFE_F00D);

        // Aliasing and ignored low bits
        do_req(0, 1'b1, 32'h1004, 32'h1234_5678, 1'b0);
        do_req(0, 1'b0, 32'h0006, 32'h0, 1'b0);
        chk("alias", get_dout(0), 32'h1234_5678);

        // Write after read leaves read data
        do_req(0, 1'b1, 32'h300, 32'h0BAD_0BAD, 1'b0);
        chk("wr_keeps_rd", get_dout(0), 32'h1234_5678);

        // Reset at second BUSY edge of a write to 0x80
        do_req(0, 1'b1, 32'h80, 32'hA5A5_0001, 1'b0);
        idle(0, 1);
        req_valid[0] = 1'b1; we_memory[0] = 1'b1; mem_addr[0] = 32'h80;
        set_din(0, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        rst_b[0] = 1'b0;
        @(posedge clk); #1;
        chk("midrst_ready", 32'(mem_ready[0]), 32'd0);
        chk("midrst_busy", 32'(mem_busy[0]), 32'd0);
        chk("midrst_data", get_dout(0), 32'h0);
        last_rd[0] = 32'h0;
        rst_b[0] = 1'b1;
        idle(0, 4);
        do_req(0, 1'b0, 32'h80, 32'h0, 1'b0);
        chk("midrst_nowrite", get_dout(0), 32'hA5A5_0001);

        // LATENCY=1: reset coinciding with the completion edge
        do_req(1, 1'b1, 32'h100, 32'h1111_2222, 1'b0);
        idle(1, 1);
        req_valid[1] = 1'b1; we_memory[1] = 1'b1; mem_addr[1] = 32'h100;
        set_din(1, 32'h9999_9999);
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        rst_b[1] = 1'b0;
        @(posedge clk); #1;
        chk("cmprst_ready", 32'(mem_ready[1]), 32'd0);
        chk("cmprst_data", get_dout(1), 32'h0);
        last_rd[1] = 32'h0;
        rst_b[1] = 1'b1;
        idle(1, 2);
        do_req(1, 1'b0, 32'h100, 32'h0, 1'b0);
        chk("cmprst_nowrite", get_dout(1), 32'h1111_2222);

        // LATENCY=1 back-to-back: writes, then chained reads
        do_req(1, 1'b1, 32'h10, 32'hAAAA_0010, 1'b0);
        do_req(1, 1'b1, 32'h14, 32'hAAAA_0014, 1'b0);
        do_req(1, 1'b1, 32'h18, 32'hAAAA_0018, 1'b0);
        do_req(1, 1'b0, 32'h10, 32'h0, 1'b0);
        do_req(1, 1'b0, 32'h18, 32'h0, 1'b0);
        do_req(1, 1'b0, 32'h14, 32'h0, 1'b0);
        chk("b2b_last", get_dout(1), 32'hAAAA_0014);
        idle(1, 1);

        // Randomized traffic on both instances
        for (int s = 0; s < 2; s++) begin
            for (int n = 0; n < 30; n++) begin
                int qsz;
                qsz = (s == 0) ? wq0.size() : wq1.size();
                if (qsz == 0 || $urandom_range(1, 0) == 1) begin
                    a = $urandom;
                    d = $urandom;
                    if (s == 0) wq0.push_back(int'(a[11:2]));
                    else        wq1.push_back(int'(a[11:2]));
                    do_req(s, 1'b1, a, d, ($urandom_range(3, 0) == 0));
                end else begin
                    idx = (s == 0) ? wq0[$urandom_range(qsz - 1, 0)]
                                   : wq1[$urandom_range(qsz - 1, 0)];
                    a = $urandom;
                    a[11:2] = 10'(idx);
                    do_req(s, 1'b0, a, 32'h0, ($urandom_range(3, 0) == 0));
                end
                if ($urandom_range(2, 0) != 0) idle(s, $urandom_range(2, 1));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
